// File: rtl/ahb_burst_sequencer.sv
// AHB manager address-phase sequencer.
// Accepts one burst request, checks it, and then drives the address-phase signals
// (htrans/haddr/hburst/hsize/hwrite) beat by beat under hready/hresp control.
// Ports:
//   HCLK, HRESETn         clock, async active-low reset
//   req_*                 burst request handshake (valid/ready) and reject pulse
//   haddr..hwrite         AHB address-phase outputs
//   hready, hresp         combined slave response
//   dphase_valid/_beat    which beat currently occupies the data phase
//   done, done_err        burst completion pulse and its error qualifier
module ahb_burst_sequencer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_burst,
    input  logic [2:0]            req_size,
    input  logic                  req_write,
    input  logic [4:0]            req_len,
    output logic                  req_err,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic [2:0]            hburst,
    output logic [2:0]            hsize,
    output logic                  hwrite,
    input  logic                  hready,
    input  logic                  hresp,
    output logic                  dphase_valid,
    output logic [3:0]            dphase_beat,
    output logic                  done,
    output logic                  done_err
);

    localparam logic [2:0] MaxSize      = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST_DATA} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [2:0]            hburst_q, hburst_d;
    logic [2:0]            hsize_q, hsize_d;
    logic                  hwrite_q, hwrite_d;
    logic [4:0]            beats_q, beats_d;   // total beats in the burst
    logic [4:0]            abeat_q, abeat_d;   // index of the beat in its address phase
    logic                  dphase_valid_q, dphase_valid_d;
    logic [3:0]            dphase_beat_q, dphase_beat_d;
    logic                  err_q, err_d;       // an ERROR response was seen this burst
    logic                  req_err_q, req_err_d;

    // Request decode
    logic [4:0]            req_beats;
    logic [ADDR_WIDTH-1:0] req_step;
    logic [ADDR_WIDTH-1:0] req_addr_al;
    logic [ADDR_WIDTH-1:0] req_last;
    logic                  req_bad;

    always_comb begin
        case (req_burst)
            3'd0:       req_beats = 5'd1;
            3'd1: begin
                if (req_len == 5'd0) begin
                    req_beats = 5'd1;
                end else if (req_len > 5'd16) begin
                    req_beats = 5'd16;
                end else begin
                    req_beats = req_len;
                end
            end
            3'd2, 3'd3: req_beats = 5'd4;
            3'd4, 3'd5: req_beats = 5'd8;
            default:    req_beats = 5'd16;
        endcase
    end

    assign req_step    = ADDR_WIDTH'(1) << req_size;
    assign req_addr_al = req_addr & ~(req_step - ADDR_WIDTH'(1));
    assign req_last    = req_addr_al + (ADDR_WIDTH'(req_beats) << req_size) - ADDR_WIDTH'(1);
    // Odd burst encodings are the incrementing ones; only those can cross a 1KB page.
    assign req_bad     = (req_size > MaxSize) ||
                         (req_burst[0] && ((req_last >> 10) != (req_addr_al >> 10)));

    // Next-address generation for the burst in flight
    logic [ADDR_WIDTH-1:0] cur_step;
    logic [ADDR_WIDTH-1:0] wrap_len;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  is_wrap;

    assign cur_step  = ADDR_WIDTH'(1) << hsize_q;
    assign wrap_len  = ADDR_WIDTH'(beats_q) << hsize_q;
    assign incr_addr = haddr_q + cur_step;
    assign is_wrap   = !hburst_q[0] && (hburst_q != 3'd0);
    assign next_addr = is_wrap ? ((haddr_q & ~(wrap_len - ADDR_WIDTH'(1))) |
                                  (incr_addr & (wrap_len - ADDR_WIDTH'(1))))
                               : incr_addr;

    always_comb begin
        state_d        = state_q;
        haddr_d        = haddr_q;
        htrans_d       = htrans_q;
        hburst_d       = hburst_q;
        hsize_d        = hsize_q;
        hwrite_d       = hwrite_q;
        beats_d        = beats_q;
        abeat_d        = abeat_q;
        dphase_valid_d = dphase_valid_q;
        dphase_beat_d  = dphase_beat_q;
        err_d          = err_q;
        req_err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        req_err_d = 1'b1;
                    end else begin
                        state_d  = S_ADDR;
                        htrans_d = HtransNonseq;
                        haddr_d  = req_addr_al;
                        hburst_d = req_burst;
                        hsize_d  = req_size;
                        hwrite_d = req_write;
                        beats_d  = req_beats;
                        abeat_d  = 5'd0;
                        err_d    = 1'b0;
                    end
                end
            end
            S_ADDR: begin
                if (hready) begin
                    dphase_valid_d = 1'b1;
                    dphase_beat_d  = abeat_q[3:0];
                    if (abeat_q + 5'd1 < beats_q) begin
                        htrans_d = HtransSeq;
                        haddr_d  = next_addr;
                        abeat_d  = abeat_q + 5'd1;
                    end else begin
                        htrans_d = HtransIdle;
                        state_d  = S_LAST_DATA;
                    end
                end else if (hresp && dphase_valid_q) begin
                    // First ERROR cycle: cancel the pending address phase and the rest.
                    htrans_d = HtransIdle;
                    err_d    = 1'b1;
                    state_d  = S_LAST_DATA;
                end
            end
            S_LAST_DATA: begin
                if (hready) begin
                    dphase_valid_d = 1'b0;
                    err_d          = 1'b0;
                    state_d        = S_IDLE;
                end else if (hresp) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q        <= S_IDLE;
            haddr_q        <= '0;
            htrans_q       <= HtransIdle;
            hburst_q       <= 3'd0;
            hsize_q        <= 3'd0;
            hwrite_q       <= 1'b0;
            beats_q        <= 5'd0;
            abeat_q        <= 5'd0;
            dphase_valid_q <= 1'b0;
            dphase_beat_q  <= 4'd0;
            err_q          <= 1'b0;
            req_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            haddr_q        <= haddr_d;
            htrans_q       <= htrans_d;
            hburst_q       <= hburst_d;
            hsize_q        <= hsize_d;
            hwrite_q       <= hwrite_d;
            beats_q        <= beats_d;
            abeat_q        <= abeat_d;
            dphase_valid_q <= dphase_valid_d;
            dphase_beat_q  <= dphase_beat_d;
            err_q          <= err_d;
            req_err_q      <= req_err_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign req_err      = req_err_q;
    assign haddr        = haddr_q;
    assign htrans       = htrans_q;
    assign hburst       = hburst_q;
    assign hsize        = hsize_q;
    assign hwrite       = hwrite_q;
    assign dphase_valid = dphase_valid_q;
    assign dphase_beat  = dphase_beat_q;
    // The last data phase completes in the cycle hready is seen in S_LAST_DATA.
    assign done         = (state_q == S_LAST_DATA) && hready;
    assign done_err     = done && (err_q || hresp);

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// Scoreboard bench for ahb_burst_sequencer: stimulus pushes expected beats computed
// from burst rules; a negedge monitor pops and compares whenever the DUT presents them.
module tb_ahb_burst_sequencer;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_burst = '0;
    logic [2:0]  req_size = '0;
    logic        req_write = 1'b0;
    logic [4:0]  req_len = '0;
    logic        req_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic        dphase_valid;
    logic [3:0]  dphase_beat;
    logic        done;
    logic        done_err;

    ahb_burst_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_burst(req_burst), .req_size(req_size), .req_write(req_write),
        .req_len(req_len), .req_err(req_err),
        .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hwrite(hwrite),
        .hready(hready), .hresp(hresp),
        .dphase_valid(dphase_valid), .dphase_beat(dphase_beat),
        .done(done), .done_err(done_err)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [2:0]  size;
        logic        write;
    } beat_t;

    beat_t exp_addr_q[$];
    int    exp_dbeat_q[$];
    bit    exp_done_q[$];
    bit    exp_rej_q[$];

    int compared = 0;
    int mismatched = 0;

    function automatic void chk(input string name, input longint unsigned act,
                                input longint unsigned exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Slave responder controls
    int          wait_pct = 0;
    bit          err_armed = 1'b0;
    int          err_beat = 0;
    bit          err_phase = 1'b0;
    logic [31:0] stall_addr = '0;
    int          stall_left = 0;

    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            if (!HRESETn) begin
                hready    = 1'b1;
                hresp     = 1'b0;
                err_phase = 1'b0;
            end else if (err_phase) begin
                hready    = 1'b1;
                hresp     = 1'b1;
                err_phase = 1'b0;
                err_armed = 1'b0;
            end else if (err_armed && dphase_valid && (int'(dphase_beat) == err_beat)) begin
                hready    = 1'b0;
                hresp     = 1'b1;
                err_phase = 1'b1;
            end else if (stall_left > 0 && htrans != T_IDLE && haddr == stall_addr) begin
                hready = 1'b0;
                hresp  = 1'b0;
                stall_left--;
            end else begin
                hready = (wait_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= wait_pct);
                hresp  = 1'b0;
            end
        end
    end

    // Monitor
    beat_t mon_e;
    int    mon_b;
    bit    mon_d;
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (htrans != T_IDLE) chk("no_busy", htrans == T_BUSY, 0);
            if (htrans != T_IDLE && hready) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_addr_phase", htrans, T_IDLE);
                end else begin
                    mon_e = exp_addr_q.pop_front();
                    chk("haddr", haddr, mon_e.addr);
                    chk("htrans", htrans, mon_e.trans);
                    chk("hburst", hburst, mon_e.burst);
                    chk("hsize", hsize, mon_e.size);
                    chk("hwrite", hwrite, mon_e.write);
                end
            end
            if (dphase_valid && hready) begin
                if (exp_dbeat_q.size() == 0) begin
                    chk("unexpected_dphase", dphase_valid, 0);
                end else begin
                    mon_b = exp_dbeat_q.pop_front();
                    chk("dphase_beat", dphase_beat, mon_b);
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    mon_d = exp_done_q.pop_front();
                    chk("done_err", done_err, mon_d);
                end
            end
            if (req_err) begin
                if (exp_rej_q.size() == 0) begin
                    chk("unexpected_req_err", req_err, 0);
                end else begin
                    void'(exp_rej_q.pop_front());
                    chk("req_err_ready", req_ready, 1);
                end
            end
        end
    end

    // Reference model: beat count from burst encoding
    function automatic int model_beats(input logic [2:0] b, input logic [4:0] len);
        case (b)
            3'd0:       return 1;
            3'd1:       return (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic start_req(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                             input logic w, input logic [4:0] len, input int eb,
                             output bit legal);
        int              n;
        int              beats;
        int              nexp;
        longint unsigned step, st, wl, ad;
        beat_t           e;
        n = 0;
        while (!req_ready && n < 400) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        if (!req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: req_ready=%0d after %0d cycles, expected 1", req_ready, n);
        end
        beats = model_beats(b, len);
        step  = longint'(1) << s;
        st    = longint'(a) & ~(step - 1);
        legal = (s <= 3'd2) && !(b[0] && (((st + beats * step - 1) >> 10) != (st >> 10)));
        if (legal) begin
            nexp = (eb >= 0 && eb < beats) ? eb + 1 : beats;
            wl   = beats * step;
            for (int i = 0; i < nexp; i++) begin
                if (b == 3'd0 || b[0]) ad = st + i * step;
                else ad = (st / wl) * wl + ((st % wl) + i * step) % wl;
                e.addr  = 32'(ad);
                e.trans = (i == 0) ? T_NONSEQ : T_SEQ;
                e.burst = b;
                e.size  = s;
                e.write = w;
                exp_addr_q.push_back(e);
                exp_dbeat_q.push_back(i);
            end
            exp_done_q.push_back(eb >= 0);
            err_armed = (eb >= 0);
            err_beat  = eb;
        end else begin
            exp_rej_q.push_back(1'b1);
        end
        req_addr  = a;
        req_burst = b;
        req_size  = s;
        req_write = w;
        req_len   = len;
        req_valid = 1'b1;
        @(posedge HCLK);
        #1;
        req_valid = 1'b0;
        if (!legal) begin
            chk("req_err_pulse", req_err, 1);
            chk("rejected_htrans", htrans, T_IDLE);
            chk("rejected_ready", req_ready, 1);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge HCLK);
            cyc++;
            if (done) break;
            if (cyc >= 400) begin
                compared++;
                mismatched++;
                $display("FAIL done_timeout: done=0 after %0d cycles, expected a done pulse", cyc);
                break;
            end
        end
    endtask

    task automatic run_req(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                           input logic w, input logic [4:0] len, input int eb,
                           output int cyc);
        bit legal;
        cyc = 0;
        start_req(a, b, s, w, len, eb, legal);
        if (legal) begin
            wait_done(cyc);
            @(posedge HCLK);
            #1;
            chk("leftover_addr", exp_addr_q.size(), 0);
            chk("leftover_dbeat", exp_dbeat_q.size(), 0);
            chk("leftover_done", exp_done_q.size(), 0);
        end
    endtask

    int          cyc;
    bit          lg;
    logic [31:0] ra;
    logic [2:0]  rb, rs;
    logic [4:0]  rl;
    int          rbeats, reb;

    initial begin
        #2;
        chk("rst_htrans", htrans, T_IDLE);
        chk("rst_haddr", haddr, 0);
        chk("rst_hburst", hburst, 0);
        chk("rst_hsize", hsize, 0);
        chk("rst_hwrite", hwrite, 0);
        chk("rst_dphase_valid", dphase_valid, 0);
        chk("rst_dphase_beat", dphase_beat, 0);
        chk("rst_done", done, 0);
        chk("rst_req_err", req_err, 0);
        chk("rst_req_ready", req_ready, 1);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        // Directed cases
        wait_pct = 0;
        run_req(32'h100, 3'd3, 3'd2, 1'b1, 5'd0, -1, cyc);
        chk("incr4_done_latency", cyc, 5);
        chk("hold_hburst", hburst, 3'd3);
        chk("hold_hsize", hsize, 3'd2);
        chk("hold_hwrite", hwrite, 1);
        run_req(32'h38, 3'd2, 3'd2, 1'b0, 5'd0, -1, cyc);
        run_req(32'h0A, 3'd4, 3'd1, 1'b1, 5'd0, -1, cyc);
        run_req(32'h3F0, 3'd5, 3'd2, 1'b1, 5'd0, -1, cyc);
        run_req(32'h40, 3'd0, 3'd3, 1'b0, 5'd0, -1, cyc);
        stall_addr = 32'h204;
        stall_left = 2;
        run_req(32'h200, 3'd3, 3'd2, 1'b0, 5'd0, -1, cyc);
        chk("incr4_stall_latency", cyc, 7);
        run_req(32'h000, 3'd5, 3'd2, 1'b1, 5'd0, 2, cyc);
        run_req(32'h3F8, 3'd1, 3'd0, 1'b0, 5'd0, -1, cyc);

        // Asynchronous reset in the middle of a WRAP16
        start_req(32'h40, 3'd6, 3'd2, 1'b1, 5'd0, -1, lg);
        repeat (6) @(posedge HCLK);
        #3;
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_htrans", htrans, T_IDLE);
        chk("mid_rst_haddr", haddr, 0);
        chk("mid_rst_hburst", hburst, 0);
        chk("mid_rst_hsize", hsize, 0);
        chk("mid_rst_hwrite", hwrite, 0);
        chk("mid_rst_dphase_valid", dphase_valid, 0);
        exp_addr_q.delete();
        exp_dbeat_q.delete();
        exp_done_q.delete();
        err_armed = 1'b0;
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 1);
        run_req(32'h80, 3'd0, 3'd2, 1'b1, 5'd0, -1, cyc);
        chk("single_done_latency", cyc, 2);

        // Randomized bursts with wait states and injected errors
        wait_pct = 25;
        for (int it = 0; it < 60; it++) begin
            ra = 32'($urandom_range(0, 32'hFFF));
            rb = 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            rl = 5'($urandom_range(0, 16));
            rbeats = model_beats(rb, rl);
            reb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rbeats - 1)) : -1;
            run_req(ra, rb, rs, 1'($urandom_range(0, 1)), rl, reb, cyc);
        end

        repeat (4) @(posedge HCLK);
        #1;
        chk("final_rej_queue", exp_rej_q.size(), 0);
        chk("final_addr_queue", exp_addr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ahb_burst_sequencer.md
Name: ahb_burst_sequencer

Overview:
Manager-side AHB address-phase engine that sits directly upstream of the AHB bus signals defined in AhbGlobalPackage. It accepts one burst request (start address, ahbBurstEnum, ahbHsizeEnum, direction), then drives HTRANS/HADDR/HBURST/HSIZE/HWRITE beat by beat under HREADY/HRESP control. It also publishes data-phase beat tracking so the HWDATA/HRDATA path knows which beat is in its data phase.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width; legal hsize is at most log2(DATA_WIDTH/8)

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESETn  in  1  asynchronous active-low reset
req_valid  in  1  burst request valid
req_ready  out  1  sequencer can accept a request
req_addr  in  ADDR_WIDTH  start address
req_burst  in  3  ahbBurstEnum
req_size  in  3  ahbHsizeEnum
req_write  in  1  1 = write
req_len  in  5  beat count for INCR only (0 is treated as 1, max 16)
req_err  out  1  one-cycle pulse: request rejected, nothing issued
haddr  out  ADDR_WIDTH  HADDR
htrans  out  2  ahbTransferEnum
hburst  out  3  HBURST
hsize  out  3  HSIZE
hwrite  out  1  HWRITE
hready  in  1  combined HREADY
hresp  in  1  ahbRespEnum
dphase_valid  out  1  a beat is in its data phase this cycle
dphase_beat  out  4  index of that beat (0-based)
done  out  1  one-cycle pulse when the final data phase completes or the burst is aborted
done_err  out  1  qualifies done; 1 = burst aborted by ERROR

Behaviour:
- Reset values (applied asynchronously, including mid-burst):
  - htrans=IDLE, haddr=0, hburst=SINGLE, hsize=BYTE, hwrite=0.
  - dphase_valid=0, dphase_beat=0, done=0, done_err=0, req_err=0.
  - State = S_IDLE.
- States: S_IDLE, S_ADDR, S_LAST_DATA.
- req_ready=1 only in S_IDLE. A request is accepted on a cycle with req_valid=1 in S_IDLE.
- Beat count:
  - SINGLE=1.
  - INCR=req_len, with 0 mapped to 1.
  - WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
- Request checks at acceptance. If either check fails, assert req_err for the next cycle, stay in S_IDLE, and drive nothing onto the bus:
  - req_size exceeds the bus width.
  - For INCR/INCR4/INCR8/INCR16 only: the burst would cross a 1KB boundary, i.e. bit 10 or above of (start + beats*step - 1) differs from start.
- Alignment: address bits below req_size are cleared on acceptance.
- step = 1 << hsize.
- Next address:
  - INCR types: addr + step.
  - WRAP types: with W = beats*step, next = (addr & ~(W-1)) | ((addr+step) & (W-1)).
- Acceptance cycle N → cycle N+1: S_ADDR, htrans=NONSEQ, haddr=start, and hburst/hsize/hwrite registered.
- While in S_ADDR, on each cycle with hready=1:
  - The current address phase completes and that beat enters its data phase next cycle (dphase_valid=1, dphase_beat=index).
  - If beats remain: htrans=SEQ, haddr=next.
  - Otherwise: htrans=IDLE and the state moves to S_LAST_DATA.
- hready=0: all address-phase outputs hold; the data-phase outputs also hold.
- S_LAST_DATA: when hready=1, pulse done (done_err=0) in that cycle and go to S_IDLE. dphase_valid drops the following cycle.
- ERROR handling:
  - hresp=ERROR with hready=0 (first error cycle) sampled while dphase_valid=1 → htrans=IDLE next cycle; remaining beats are cancelled.
  - On the second error cycle (hready=1): done=1 and done_err=1, then go to S_IDLE.
  - An ERROR in the last beat's data phase also sets done_err.
- BUSY is never generated. hburst for INCR requests is driven as INCR.
- HWRITE/HSIZE/HBURST stay stable for the whole burst and hold their last value after the burst ends.

Test Plan:
- INCR4 WORD write at 0x100, hready=1 → NONSEQ 0x100, SEQ 0x104, 0x108, 0x10C; then IDLE; done on the 5th cycle after acceptance; dphase_beat 0..3.
- WRAP4 WORD at 0x38 → haddr 0x38, 0x3C, 0x30, 0x34. WRAP8 HALFWORD at 0x0A → 0x0A, 0x0C, 0x0E, 0x00, 0x02, 0x04, 0x06, 0x08.
- INCR8 WORD at 0x3F0 → req_err=1 for one cycle, htrans stays IDLE, req_ready stays 1. req_size=DOUBLEWORD with DATA_WIDTH=32 → req_err.
- INCR4 at 0x200 with hready=0 for 2 cycles on beat 1 → haddr=0x204/SEQ held 3 cycles; final addresses unchanged; done delayed by 2 cycles.
- INCR8 with hresp=ERROR/hready=0 in beat 2's data phase → htrans=IDLE next cycle; done=1 and done_err=1 on hready=1; no beat ≥4 addresses issued.
- Deassert HRESETn mid-WRAP16 → htrans=IDLE and haddr=0 immediately; req_ready=1 after release; a new SINGLE request issues NONSEQ normally.
